// File: rtl/vga_timing_gen.sv
// Runtime-programmable VGA/VESA timing generator: polarity-configurable syncs, data enable,
// pixel coordinates and line/frame strobes, with new timing applied only at frame boundaries.
module vga_timing_gen #(
   parameter int unsigned CW         = 12,
   parameter int unsigned FCW        = 8,
   parameter int unsigned DEF_H_ACT  = 640,
   parameter int unsigned DEF_H_FP   = 16,
   parameter int unsigned DEF_H_SYNC = 96,
   parameter int unsigned DEF_H_BP   = 48,
   parameter int unsigned DEF_V_ACT  = 480,
   parameter int unsigned DEF_V_FP   = 10,
   parameter int unsigned DEF_V_SYNC = 2,
   parameter int unsigned DEF_V_BP   = 33,
   parameter logic [1:0]  DEF_POL    = 2'b00
) (
   input  logic            px_clk,
   input  logic            reset_n,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [4*CW-1:0] cfg_h,
   input  logic [4*CW-1:0] cfg_v,
   input  logic [1:0]      cfg_pol,
   output logic            cfg_err,
   output logic            hsync,
   output logic            vsync,
   output logic            de,
   output logic [CW-1:0]   x_px,
   output logic [CW-1:0]   y_px,
   output logic            line_start,
   output logic            frame_start,
   output logic [FCW-1:0]  frame_cnt
);

   typedef struct packed {
      logic [CW-1:0] act;
      logic [CW-1:0] fp;
      logic [CW-1:0] sync;
      logic [CW-1:0] bp;
   } axis_t;

   typedef enum logic {
      ST_IDLE,
      ST_PENDING
   } cfg_state_t;

   localparam axis_t DEF_H = '{act: CW'(DEF_H_ACT), fp: CW'(DEF_H_FP),
                               sync: CW'(DEF_H_SYNC), bp: CW'(DEF_H_BP)};
   localparam axis_t DEF_V = '{act: CW'(DEF_V_ACT), fp: CW'(DEF_V_FP),
                               sync: CW'(DEF_V_SYNC), bp: CW'(DEF_V_BP)};

   // Totals are summed two bits wider so an oversized offer is detectable, not wrapped.
   function automatic logic axis_ok(input axis_t a);
      logic [CW+1:0] total;
      total = {2'b00, a.act} + {2'b00, a.fp} + {2'b00, a.sync} + {2'b00, a.bp};
      return (a.act != '0) && (a.fp != '0) && (a.sync != '0) && (a.bp != '0) &&
             (total[CW+1:CW] == 2'b00);
   endfunction

   cfg_state_t     state_q, state_d;

   axis_t          h_q, h_d, v_q, v_d;
   axis_t          sh_h_q, sh_h_d, sh_v_q, sh_v_d;
   logic [1:0]     pol_q, pol_d, sh_pol_q, sh_pol_d;
   logic [CW-1:0]  hc_q, hc_d, vc_q, vc_d;

   logic           hsync_q, hsync_d;
   logic           vsync_q, vsync_d;
   logic           de_q, de_d;
   logic [CW-1:0]  x_q, x_d, y_q, y_d;
   logic           ls_q, ls_d;
   logic           fs_q, fs_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic           err_q, err_d;

   axis_t          cfg_h_s, cfg_v_s;
   logic           offer, cfg_ok, accept, reject, apply;
   logic [CW-1:0]  h_blank, v_blank, h_last, v_last, h_sync_end, v_sync_end;
   logic           h_wrap, v_wrap, frame_end;

   assign cfg_h_s = axis_t'(cfg_h);
   assign cfg_v_s = axis_t'(cfg_v);

   always_comb begin
      h_blank    = h_q.fp + h_q.sync + h_q.bp;
      v_blank    = v_q.fp + v_q.sync + v_q.bp;
      h_last     = h_blank + h_q.act - CW'(1);
      v_last     = v_blank + v_q.act - CW'(1);
      h_sync_end = h_q.fp + h_q.sync;
      v_sync_end = v_q.fp + v_q.sync;
      h_wrap     = (hc_q == h_last);
      v_wrap     = (vc_q == v_last);
      frame_end  = h_wrap && v_wrap;
   end

   always_comb begin
      cfg_ok = axis_ok(cfg_h_s) && axis_ok(cfg_v_s);
      offer  = cfg_valid && cfg_ready;
      accept = offer && cfg_ok;
      reject = offer && !cfg_ok;
      apply  = (state_q == ST_PENDING) && frame_end;
   end

   // Config FSM: state register
   always_ff @(posedge px_clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Config FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept) state_d = ST_PENDING;
         ST_PENDING: if (apply)  state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Config FSM: outputs
   always_comb begin
      cfg_ready = (state_q == ST_IDLE);
   end

   // Accept only happens in IDLE and apply only in PENDING, so they never collide.
   always_comb begin
      sh_h_d   = sh_h_q;
      sh_v_d   = sh_v_q;
      sh_pol_d = sh_pol_q;
      h_d      = h_q;
      v_d      = v_q;
      pol_d    = pol_q;
      if (accept) begin
         sh_h_d   = cfg_h_s;
         sh_v_d   = cfg_v_s;
         sh_pol_d = cfg_pol;
      end
      if (apply) begin
         h_d   = sh_h_q;
         v_d   = sh_v_q;
         pol_d = sh_pol_q;
      end
   end

   always_comb begin
      hc_d = hc_q + CW'(1);
      vc_d = vc_q;
      if (h_wrap) begin
         hc_d = '0;
         vc_d = v_wrap ? '0 : vc_q + CW'(1);
      end
   end

   always_comb begin
      hsync_d = ((hc_q >= h_q.fp) && (hc_q < h_sync_end)) ? pol_q[0] : ~pol_q[0];
      vsync_d = ((vc_q >= v_q.fp) && (vc_q < v_sync_end)) ? pol_q[1] : ~pol_q[1];
      de_d    = (hc_q >= h_blank) && (vc_q >= v_blank);
      x_d     = de_d ? hc_q - h_blank : '0;
      y_d     = de_d ? vc_q - v_blank : '0;
      ls_d    = de_d && (hc_q == h_blank);
      fs_d    = ls_d && (vc_q == v_blank);
      fcnt_d  = fcnt_q + FCW'(fs_d);
      err_d   = reject;
   end

   always_ff @(posedge px_clk) begin
      if (!reset_n) begin
         h_q      <= DEF_H;
         v_q      <= DEF_V;
         pol_q    <= DEF_POL;
         sh_h_q   <= '0;
         sh_v_q   <= '0;
         sh_pol_q <= '0;
         hc_q     <= '0;
         vc_q     <= '0;
         hsync_q  <= ~DEF_POL[0];
         vsync_q  <= ~DEF_POL[1];
         de_q     <= 1'b0;
         x_q      <= '0;
         y_q      <= '0;
         ls_q     <= 1'b0;
         fs_q     <= 1'b0;
         fcnt_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         h_q      <= h_d;
         v_q      <= v_d;
         pol_q    <= pol_d;
         sh_h_q   <= sh_h_d;
         sh_v_q   <= sh_v_d;
         sh_pol_q <= sh_pol_d;
         hc_q     <= hc_d;
         vc_q     <= vc_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         de_q     <= de_d;
         x_q      <= x_d;
         y_q      <= y_d;
         ls_q     <= ls_d;
         fs_q     <= fs_d;
         fcnt_q   <= fcnt_d;
         err_q    <= err_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x_px        = x_q;
   assign y_px        = y_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fcnt_q;
   assign cfg_err     = err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small test mode (12x7 totals): a per-cycle scoreboard
// plus directed checks on latency, widths, config handshake and mid-frame reset.
module tb_vga_timing_gen;

   localparam int CW  = 12;
   localparam int FCW = 8;

   typedef struct packed {
      logic           rdy;
      logic           err;
      logic           hs;
      logic           vs;
      logic           de;
      logic [CW-1:0]  x;
      logic [CW-1:0]  y;
      logic           ls;
      logic           fs;
      logic [FCW-1:0] fc;
   } obs_t;

   logic            px_clk = 1'b0;
   logic            reset_n;
   logic            cfg_valid;
   logic            cfg_ready;
   logic [4*CW-1:0] cfg_h;
   logic [4*CW-1:0] cfg_v;
   logic [1:0]      cfg_pol;
   logic            cfg_err;
   logic            hsync;
   logic            vsync;
   logic            de;
   logic [CW-1:0]   x_px;
   logic [CW-1:0]   y_px;
   logic            line_start;
   logic            frame_start;
   logic [FCW-1:0]  frame_cnt;

   always #5 px_clk = ~px_clk;

   vga_timing_gen #(
      .CW(CW), .FCW(FCW),
      .DEF_H_ACT(8), .DEF_H_FP(2), .DEF_H_SYNC(1), .DEF_H_BP(1),
      .DEF_V_ACT(4), .DEF_V_FP(1), .DEF_V_SYNC(1), .DEF_V_BP(1),
      .DEF_POL(2'b00)
   ) dut (
      .px_clk(px_clk), .reset_n(reset_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pol(cfg_pol), .cfg_err(cfg_err),
      .hsync(hsync), .vsync(vsync), .de(de), .x_px(x_px), .y_px(y_px),
      .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   obs_t exp_q[$];

   // Reference model: field index 0 = act, 1 = fp, 2 = sync, 3 = bp.
   int         m_h[4], m_v[4], m_sh_h[4], m_sh_v[4];
   logic [1:0] m_pol, m_sh_pol;
   bit         m_pend;
   int         m_hc, m_vc;
   obs_t       m_out = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      assert (got === want)
      else begin
         n_fail++;
         $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, got, want);
      end
   endtask

   function automatic int fld(input logic [4*CW-1:0] c, input int i);
      return int'(c[(3-i)*CW +: CW]);
   endfunction

   task automatic tick();
      obs_t e, got, want;
      int   hb, vb, ht, vt, sh, sv;
      bit   old_pend, ok;
      e = '0;
      if (!reset_n) begin
         m_h = '{8, 2, 1, 1};
         m_v = '{4, 1, 1, 1};
         m_pol = 2'b00;
         m_pend = 0;
         m_hc = 0;
         m_vc = 0;
         e.rdy = 1'b1;
         e.hs = 1'b1;
         e.vs = 1'b1;
      end else begin
         hb = m_h[1] + m_h[2] + m_h[3];
         vb = m_v[1] + m_v[2] + m_v[3];
         ht = hb + m_h[0];
         vt = vb + m_v[0];
         e.hs = (m_hc >= m_h[1] && m_hc < m_h[1] + m_h[2]) ? m_pol[0] : ~m_pol[0];
         e.vs = (m_vc >= m_v[1] && m_vc < m_v[1] + m_v[2]) ? m_pol[1] : ~m_pol[1];
         e.de = (m_hc >= hb) && (m_vc >= vb);
         if (e.de) begin
            e.x = CW'(m_hc - hb);
            e.y = CW'(m_vc - vb);
         end
         e.ls = e.de && (m_hc == hb);
         e.fs = e.ls && (m_vc == vb);
         e.fc = m_out.fc + FCW'(e.fs);
         old_pend = m_pend;
         if (!old_pend && cfg_valid) begin
            ok = 1;
            sh = 0;
            sv = 0;
            for (int i = 0; i < 4; i++) begin
               if (fld(cfg_h, i) == 0 || fld(cfg_v, i) == 0) ok = 0;
               sh += fld(cfg_h, i);
               sv += fld(cfg_v, i);
            end
            if (sh > 4095 || sv > 4095) ok = 0;
            if (ok) begin
               for (int i = 0; i < 4; i++) begin
                  m_sh_h[i] = fld(cfg_h, i);
                  m_sh_v[i] = fld(cfg_v, i);
               end
               m_sh_pol = cfg_pol;
               m_pend = 1;
            end else begin
               e.err = 1'b1;
            end
         end
         if (m_hc == ht - 1) begin
            m_hc = 0;
            if (m_vc == vt - 1) begin
               m_vc = 0;
               if (old_pend) begin
                  m_h = m_sh_h;
                  m_v = m_sh_v;
                  m_pol = m_sh_pol;
                  m_pend = 0;
               end
            end else begin
               m_vc++;
            end
         end else begin
            m_hc++;
         end
         e.rdy = !m_pend;
      end
      m_out = e;
      exp_q.push_back(e);
      @(posedge px_clk);
      #1;
      got = '{rdy: cfg_ready, err: cfg_err, hs: hsync, vs: vsync, de: de, x: x_px,
              y: y_px, ls: line_start, fs: frame_start, fc: frame_cnt};
      want = exp_q.pop_front();
      check("cycle", 64'(got), 64'(want));
   endtask

   // Window from one frame_start to the next; starts on a frame_start cycle.
   task automatic measure_frame(output int clks, output int dec, output int lsc,
                                output int hlo, output int vlo, output int llen);
      clks = 0; dec = 0; lsc = 0; hlo = 0; vlo = 0; llen = 0;
      do begin
         dec += int'(de);
         lsc += int'(line_start);
         hlo += int'(!hsync);
         vlo += int'(!vsync);
         if (line_start && clks > 0 && llen == 0) llen = clks;
         tick();
         clks++;
      end while (frame_start !== 1'b1 && clks < 1000);
   endtask

   task automatic wait_fs();
      int n = 0;
      while (frame_start !== 1'b1 && n < 1000) begin tick(); n++; end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (cfg_ready !== 1'b1 && n < 1000) begin tick(); n++; end
   endtask

   task automatic wait_state(input int h, input int v);
      int n = 0;
      while (!(m_hc == h && m_vc == v) && n < 1000) begin tick(); n++; end
   endtask

   task automatic line_gap(output int g);
      int n = 0;
      while (line_start !== 1'b1 && n < 500) begin tick(); n++; end
      g = 0;
      do begin tick(); g++; end while (line_start !== 1'b1 && g < 500);
   endtask

   task automatic offer(input logic [4*CW-1:0] h, input logic [4*CW-1:0] v, input logic [1:0] p);
      cfg_h = h;
      cfg_v = v;
      cfg_pol = p;
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_de"}, de, 0);
      check({tag, "_hsync"}, hsync, 1);
      check({tag, "_vsync"}, vsync, 1);
      check({tag, "_xy"}, {x_px, y_px}, 0);
      check({tag, "_strobes"}, {line_start, frame_start, cfg_err}, 0);
      check({tag, "_fcnt"}, frame_cnt, 0);
      check({tag, "_ready"}, cfg_ready, 1);
   endtask

   task automatic first_de_after_release(input string tag);
      int n = 0;
      while (de !== 1'b1 && n < 200) begin tick(); n++; end
      check({tag, "_latency"}, n, 41);
      check({tag, "_xy"}, {x_px, y_px}, 0);
      check({tag, "_strobes"}, {line_start, frame_start}, 2'b11);
      check({tag, "_fcnt"}, frame_cnt, 1);
   endtask

   initial begin
      int clks, dec, lsc, hlo, vlo, llen, g;
      reset_n = 1'b0;
      cfg_valid = 1'b0;
      cfg_h = '0;
      cfg_v = '0;
      cfg_pol = 2'b00;
      repeat (3) tick();
      check_reset_outputs("reset");

      // First frame out of reset
      reset_n = 1'b1;
      first_de_after_release("first");
      measure_frame(clks, dec, lsc, hlo, vlo, llen);
      check("f1_clks", clks, 84);
      check("f1_de_cycles", dec, 32);
      check("f1_lines", lsc, 4);
      check("f1_line_len", llen, 12);
      check("f1_fcnt", frame_cnt, 2);

      // Free run: sync widths and frame count
      for (int f = 0; f < 2; f++) begin
         measure_frame(clks, dec, lsc, hlo, vlo, llen);
         check("run_clks", clks, 84);
         check("run_hsync_low", hlo, 7);
         check("run_vsync_low", vlo, 12);
         check("run_fcnt", frame_cnt, 3 + f);
      end

      // Mid-frame offer: current frame keeps old lines
      repeat (20) tick();
      offer({12'd16, 12'd2, 12'd2, 12'd2}, {12'd4, 12'd1, 12'd1, 12'd1}, 2'b00);
      check("pend_ready_low", cfg_ready, 0);
      line_gap(g);
      check("pend_old_line_len", g, 12);
      check("pend_still_pending", cfg_ready, 0);
      wait_ready();
      check("apply_ready_high", cfg_ready, 1);
      wait_fs();
      measure_frame(clks, dec, lsc, hlo, vlo, llen);
      check("new_clks", clks, 154);
      check("new_de_cycles", dec, 64);
      check("new_line_len", llen, 22);
      check("new_hsync_low", hlo, 14);
      check("new_vsync_low", vlo, 22);

      // Rejected offers: zero field and oversized total
      offer({12'd16, 12'd2, 12'd0, 12'd2}, {12'd4, 12'd1, 12'd1, 12'd1}, 2'b00);
      check("zero_err", {cfg_err, cfg_ready}, 2'b11);
      tick();
      check("zero_err_pulse", cfg_err, 0);
      offer({12'd4090, 12'd2, 12'd2, 12'd2}, {12'd4, 12'd1, 12'd1, 12'd1}, 2'b00);
      check("ovf_err", {cfg_err, cfg_ready}, 2'b11);
      wait_fs();
      measure_frame(clks, dec, lsc, hlo, vlo, llen);
      check("rej_clks", clks, 154);
      check("rej_hsync_low", hlo, 14);

      // Accept on the frame-final pixel: applies one frame later
      wait_state(21, 6);
      offer({12'd16, 12'd2, 12'd2, 12'd2}, {12'd4, 12'd1, 12'd1, 12'd1}, 2'b11);
      check("final_px_captured", cfg_ready, 0);
      wait_fs();
      check("final_px_not_applied", cfg_ready, 0);
      check("final_px_old_pol", hsync, 1);
      wait_ready();
      wait_fs();
      measure_frame(clks, dec, lsc, hlo, vlo, llen);
      check("pol_clks", clks, 154);
      check("pol_hsync_high", clks - hlo, 14);
      check("pol_vsync_high", clks - vlo, 22);
      check("pol_idle_low", {hsync, vsync}, 0);

      // Reset mid-frame with a config pending
      wait_state(0, 0);
      offer({12'd6, 12'd3, 12'd2, 12'd1}, {12'd3, 12'd1, 12'd1, 12'd1}, 2'b01);
      check("rst_pend_ready", cfg_ready, 0);
      wait_state(5, 2);
      reset_n = 1'b0;
      tick();
      check_reset_outputs("midrst");
      reset_n = 1'b1;
      first_de_after_release("midrst_first");
      for (int f = 0; f < 2; f++) begin
         measure_frame(clks, dec, lsc, hlo, vlo, llen);
         check("def_clks", clks, 84);
         check("def_line_len", llen, 12);
         check("def_hsync_low", hlo, 7);
         check("def_ready", cfg_ready, 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
